// File: rtl/chacha20_keystream_streamer_if.sv
// Bundle of configuration, encoder-control and keystream-stream signals for
// chacha20_keystream_streamer; master = streamer side, slave = surrounding logic.
interface chacha20_keystream_streamer_if #(
  parameter int WORD_WIDTH = 32
);
  logic [511:0]          cfg_state;
  logic                  cfg_load;
  logic                  enable;
  logic [511:0]          enc_round_input;
  logic                  enc_set_state;
  logic                  enc_start_round;
  logic                  enc_finished;
  logic [511:0]          enc_round_output;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic [31:0]           block_count;

  modport master (
    input  cfg_state, cfg_load, enable, enc_finished, enc_round_output, out_ready,
    output enc_round_input, enc_set_state, enc_start_round, out_data, out_valid,
           busy, block_count
  );

  modport slave (
    output cfg_state, cfg_load, enable, enc_finished, enc_round_output, out_ready,
    input  enc_round_input, enc_set_state, enc_start_round, out_data, out_valid,
           busy, block_count
  );
endinterface

// File: rtl/chacha20_keystream_streamer.sv
// Drives a ChaCha20 serial encoder with zero plaintext and streams the resulting
// 512-bit keystream blocks as WORD_WIDTH-bit words, with one block of prefetch.
module chacha20_keystream_streamer #(
  parameter int WORD_WIDTH = 32
) (
  input  logic clock,
  input  logic clear_n,
  chacha20_keystream_streamer_if.master bus
);
  localparam int WPB   = 512 / WORD_WIDTH;
  localparam int IDX_W = $clog2(WPB);

  typedef enum logic [1:0] {
    E_IDLE      = 2'd0,
    E_WAIT_LOW  = 2'd1,
    E_WAIT_HIGH = 2'd2
  } e_state_t;

  e_state_t             r_state;
  logic [511:0]         r_cfg;
  logic                 r_configured;
  logic                 r_cfg_pending;
  logic                 r_discard;
  logic [511:0]         r_round_input;
  logic                 r_set_state;
  logic                 r_start_round;
  logic [511:0]         r_pend;
  logic                 r_pend_valid;
  logic [511:0]         r_buf;
  logic                 r_buf_valid;
  logic [IDX_W-1:0]     r_idx;
  logic [31:0]          r_block_count;

  e_state_t             w_state_next;
  logic                 w_set_next;
  logic                 w_start_next;
  logic [511:0]         w_round_next;
  logic                 w_capture;
  logic                 w_done;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_reload;

  assign w_done   = (r_state == E_WAIT_HIGH) && bus.enc_finished;
  assign w_accept = r_buf_valid && bus.out_ready;
  assign w_last   = w_accept && (r_idx == IDX_W'(WPB - 1));
  assign w_reload = r_pend_valid && (!r_buf_valid || w_last);

  // A start is held off while a set_state pulse is still on the wire so the
  // encoder never sees the two commands back to back.
  always_comb begin
    w_state_next = r_state;
    w_set_next   = 1'b0;
    w_start_next = 1'b0;
    w_round_next = r_round_input;
    w_capture    = 1'b0;
    case (r_state)
      E_IDLE: begin
        if (!bus.cfg_load) begin
          if (r_cfg_pending && bus.enc_finished) begin
            w_set_next   = 1'b1;
            w_round_next = r_cfg;
          end else if (r_configured && bus.enable && !r_cfg_pending && !r_pend_valid &&
                       bus.enc_finished && !r_set_state) begin
            w_start_next = 1'b1;
            w_round_next = '0;
            w_state_next = E_WAIT_LOW;
          end
        end
      end
      E_WAIT_LOW: begin
        if (!bus.enc_finished) begin
          w_state_next = E_WAIT_HIGH;
        end
      end
      E_WAIT_HIGH: begin
        if (bus.enc_finished) begin
          w_state_next = E_IDLE;
          w_capture    = !r_discard && !bus.cfg_load;
        end
      end
      default: w_state_next = E_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state       <= E_IDLE;
      r_cfg         <= '0;
      r_configured  <= 1'b0;
      r_cfg_pending <= 1'b0;
      r_discard     <= 1'b0;
      r_round_input <= '0;
      r_set_state   <= 1'b0;
      r_start_round <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_round_input <= w_round_next;
      r_set_state   <= w_set_next;
      r_start_round <= w_start_next;
      if (bus.cfg_load) begin
        r_cfg         <= bus.cfg_state;
        r_cfg_pending <= 1'b1;
        r_configured  <= 1'b1;
        // A reload landing on the completion edge already drops that result.
        r_discard     <= (r_state != E_IDLE) && !w_done;
      end else begin
        if (w_set_next) begin
          r_cfg_pending <= 1'b0;
        end
        if (w_done) begin
          r_discard <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_pend        <= '0;
      r_pend_valid  <= 1'b0;
      r_buf         <= '0;
      r_buf_valid   <= 1'b0;
      r_idx         <= '0;
      r_block_count <= '0;
    end else if (bus.cfg_load) begin
      r_pend_valid  <= 1'b0;
      r_buf_valid   <= 1'b0;
      r_idx         <= '0;
      r_block_count <= '0;
    end else begin
      if (w_reload) begin
        r_buf         <= r_pend;
        r_buf_valid   <= 1'b1;
        r_pend_valid  <= 1'b0;
        r_idx         <= '0;
        r_block_count <= r_block_count + 32'd1;
      end else if (w_accept) begin
        r_buf <= r_buf >> WORD_WIDTH;
        if (w_last) begin
          r_idx       <= '0;
          r_buf_valid <= 1'b0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_capture) begin
        r_pend       <= bus.enc_round_output;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign bus.enc_round_input = r_round_input;
  assign bus.enc_set_state   = r_set_state;
  assign bus.enc_start_round = r_start_round;
  assign bus.out_data        = r_buf[WORD_WIDTH-1:0];
  assign bus.out_valid       = r_buf_valid;
  assign bus.busy            = (r_state != E_IDLE);
  assign bus.block_count     = r_block_count;
endmodule
